// File: rtl/pipe_skid_stage.sv
// Elastic pipeline-stage register with a 2-entry skid buffer; in_ready is a decode of state flops only.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_skid_stage #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

  state_t state, state_nxt;
  beat_t  main_q, skid_q, in_beat;
  logic   in_fire, out_fire;
  logic   ld_main_in, ld_main_skid, ld_skid, clr_main, clr_skid;

  assign in_beat   = '{data: in_data, ctrl: in_ctrl};
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != SKID);
  assign occupancy = (state == SKID) ? 2'd2 : (state == FULL) ? 2'd1 : 2'd0;
  assign out_data  = main_q.data;
  assign out_ctrl  = main_q.ctrl;
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    clr_main     = 1'b0;
    clr_skid     = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin
        state_nxt  = FULL;
        ld_main_in = 1'b1;
      end
      FULL: begin
        if (in_fire && out_fire) begin
          ld_main_in = 1'b1;
        end else if (in_fire) begin
          state_nxt = SKID;
          ld_skid   = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
          clr_main  = 1'b1;
        end
      end
      SKID: if (out_fire) begin
        state_nxt    = FULL;
        ld_main_skid = 1'b1;
        clr_skid     = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins: any completing out_fire is already sampled downstream, so just drop everything.
    if (flush) begin
      state_nxt    = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      clr_main     = 1'b1;
      clr_skid     = 1'b1;
    end
  end

  // Only ctrl is zeroed on a bubble; stale data is harmless once write enables are inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q      <= in_beat;
      else if (ld_main_skid) main_q      <= skid_q;
      else if (clr_main)     main_q.ctrl <= '0;
      if (ld_skid)           skid_q      <= in_beat;
      else if (clr_skid)     skid_q.ctrl <= '0;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt))    stall_cnt <= stall_cnt + CNT_ONE;
      if (flush && (state != EMPTY) && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a queue models held beats, FIFO order, flush and reset.
module tb_pipe_skid_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic [7:0]  in_ctrl, out_ctrl;
  logic        in_ready, out_valid;
  logic [1:0]  occupancy;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
  } beat_t;

  beat_t sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt, flush_cnt, out_data4;
  logic [7:0]  out_ctrl4;
  logic        in_ready4, out_valid4;
  logic [1:0]  occupancy4;
  logic [3:0]  stall_cnt4, flush_cnt4;
`endif

  pipe_skid_stage #(.DATA_W(16), .CTRL_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_skid_stage #(.DATA_W(16), .CTRL_W(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_ctrl(out_ctrl4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(sb.size() < 2));
    chk("occupancy", 32'(occupancy), 32'(sb.size()));
    if (sb.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(sb[0].d));
      chk("out_ctrl", 32'(out_ctrl), 32'(sb[0].c));
    end else begin
      chk("bubble_ctrl", 32'(out_ctrl), 32'h0);
    end
  endtask

  // Called at a negedge: drive, check state left by the previous edge, update model, advance.
  task automatic cycle(input logic iv, input logic [15:0] d, input logic [7:0] c,
                       input logic ordy, input logic fl);
    logic in_f, out_f;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    in_f  = iv && (sb.size() < 2) && !fl;
    out_f = (sb.size() > 0) && ordy;
    if (out_f) void'(sb.pop_front());
    if (fl) sb.delete();
    if (in_f) sb.push_back({d, c});
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_ctrl",  32'(out_ctrl),  32'h0);
    rst_n = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
    cycle(1'b1, 16'h0101, 8'h11, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    chk("stall_cnt_10", 32'(stall_cnt), 32'd10);
    cycle(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    cycle(1'b1, 16'h0202, 8'h22, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    chk("stall_cnt_hold", 32'(stall_cnt), 32'd10);
    chk("flush_cnt_2",    32'(flush_cnt), 32'd2);
    repeat (20) cycle(1'b1, 16'h0303, 8'h33, 1'b0, 1'b0);
    chk("stall_cnt4_sat", 32'(stall_cnt4), 32'hF);
    cycle(1'b0, 16'h0, 8'h0, 1'b1, 1'b1);
    chk("flush_cnt_3", 32'(flush_cnt), 32'd3);
`endif

    // streaming at full rate
    for (int i = 1; i <= 5; i++) cycle(1'b1, 16'(i), 8'(8'h40 + i), 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

    // backpressure into the skid entry
    cycle(1'b1, 16'hAAAA, 8'h0A, 1'b1, 1'b0);
    cycle(1'b1, 16'hBBBB, 8'h0B, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 16'hCCCC, 8'h0C, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 16'hCCCC, 8'h0C, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

    // flush while both entries hold ctrl 0xFF, with a same-cycle input
    cycle(1'b1, 16'h1111, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 16'h2222, 8'hFF, 1'b0, 1'b0);
    cycle(1'b1, 16'h3333, 8'hFF, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

    // simultaneous in/out while FULL
    cycle(1'b1, 16'h1234, 8'h12, 1'b1, 1'b0);
    cycle(1'b1, 16'h5678, 8'h56, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

    // random traffic with occasional flushes
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    repeat (3) cycle(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

    // async reset while two beats are held
    cycle(1'b1, 16'hDEAD, 8'hDE, 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 8'hBE, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out_data",  32'(out_data),  32'h0);
    chk("arst_out_ctrl",  32'(out_ctrl),  32'h0);
    chk("arst_in_ready",  32'(in_ready),  32'h1);
    chk("arst_occupancy", 32'(occupancy), 32'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 16'h0F0F, 8'h0F, 1'b1, 1'b0);
    cycle(1'b1, 16'hF0F0, 8'hF0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 16'h0, 8'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
